gnrl_iq_deinterleaver: RTL and testbench
========================================

// Module: gnrl_iq_deinterleaver
// PURPOSE
//  Receive end of the interleaved IQ stream made by the IQ combiner/decimator: accepts single-word
//  stream (I word, then Q word on the next valid cycle), re-pairs into parallel I/Q outputs.
//  Buffers pairs in a small FIFO with valid/ready output handshake; flags orphan and overflow errors.
//  Sits between the decimated acquisition stream and downstream I/Q processing or storage.
// PARAMETERS
//  DATA_WIDTH      32  width of each I or Q sample word
//  FIFO_AW         3   log2 of pair-FIFO depth (depth = 2**FIFO_AW pairs)
//  CNT_WIDTH       16  width of accepted-pair counter
// PORTS
//  CLK          in   1               system clock; all logic on posedge
//  RESET_n      in   1               asynchronous, active-low reset
//  datain       in   DATA_WIDTH      interleaved input word (I then Q)
//  in_valid     in   1               datain valid this cycle; no backpressure on input
//  dataI        out  DATA_WIDTH      in-phase word of FIFO head pair
//  dataQ        out  DATA_WIDTH      quadrature word of FIFO head pair
//  out_valid    out  1               head pair valid (FIFO not empty)
//  out_ready    in   1               downstream accepts head pair when out_valid & out_ready
//  pair_cnt     out  CNT_WIDTH       pairs pushed into FIFO since reset, wraps modulo 2**CNT_WIDTH
//  fifo_level   out  FIFO_AW+1       pairs currently held, 0..2**FIFO_AW
//  orphan_err   out  1               sticky: I word not followed by Q on next cycle
//  overflow_err out  1               sticky: complete pair dropped because FIFO full
//  clr_err      in   1               synchronous clear of both sticky flags
// BEHAVIOUR
//  Reset (RESET_n low, async): FSM=S_WAIT_I, I holding reg=0, FIFO empty, dataI=dataQ=0,
//   out_valid=0, pair_cnt=0, fifo_level=0, orphan_err=0, overflow_err=0. Mid-operation reset
//   discards held I word and all buffered pairs; no output pulse follows release.
//  FSM (2 states, one-hot):
//   S_WAIT_I: in_valid=1 -> latch datain as I, go S_WAIT_Q; in_valid=0 -> stay (idle gaps legal).
//   S_WAIT_Q: in_valid=1 -> form pair {I,datain}, request push, go S_WAIT_I.
//             in_valid=0 -> orphan: drop held I, set orphan_err, go S_WAIT_I (combiner emits I,Q
//             back-to-back, so a gap after I is a framing break; next valid word is taken as I).
//  Push: on Q cycle. If FIFO not full, or full with a pop in the same cycle -> write pair,
//   pair_cnt+1. If full and no pop -> drop pair, set overflow_err, pair_cnt unchanged.
//  Latency: pair written at the edge ending the Q cycle; out_valid high the next cycle (1 cycle).
//  Output: first-word-fall-through; dataI/dataQ show head pair whenever out_valid=1, hold last
//   value when empty. Pop on out_valid & out_ready; pop on empty is ignored.
//  fifo_level: +1 push only, -1 pop only, unchanged on push+pop same cycle; never exceeds depth.
//  Pointers wrap modulo 2**FIFO_AW; full/empty via extra pointer MSB.
//  Sticky flags: clr_err clears; error event in same cycle as clr_err -> flag ends set (set wins).
//  Counter arithmetic unsigned, pair_cnt wraps all-ones -> 0 silently.
//  No combinational path from in_valid/datain to outputs; out_ready -> out_valid not combinational.
// STRUCTURE
//  Shared package gnrl_iq_pkg: FSM state localparams (S_WAIT_I, S_WAIT_Q), pair word packing
//   {I,Q} width 2*DATA_WIDTH, shared DATA_WIDTH default.
//  Sub-module gnrl_sync_fifo (WIDTH=2*DATA_WIDTH, AW=FIFO_AW, FWFT, level output, async active-low
//   reset). Top level holds FSM, I holding reg, pair_cnt, error flags.
// TESTING
//  1 Reset, then I=0x11,Q=0x22 back-to-back, out_ready=1 -> out_valid 1 cycle, dataI=0x11,
//    dataQ=0x22, pair_cnt=1, fifo_level returns 0.
//  2 Stream I/Q pairs with 1-2 idle cycles between pairs -> every pair output in order, no errors.
//  3 I=0xA1, idle cycle, then I=0xB1,Q=0xB2 -> orphan_err=1, only pair {0xB1,0xB2} output.
//  4 out_ready=0, push 9 pairs at FIFO_AW=3 -> fifo_level=8, 9th dropped, overflow_err=1,
//    pair_cnt=8; then out_ready=1 -> pairs 1..8 drained in order.
//  5 FIFO full, Q cycle coincides with pop -> pair accepted, no overflow, fifo_level stays 8.
//  6 Assert RESET_n low between I and Q with 3 pairs buffered -> all outputs reset values; next
//    valid word after release treated as I; clr_err with concurrent orphan leaves orphan_err=1.

Source files
------------

// File: rtl/gnrl_iq_pkg.sv
// Shared definitions for the IQ deinterleaver: FSM encodings and the {I,Q} pair layout.
`timescale 1ns/1ps
package gnrl_iq_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;

  // One-hot pairing FSM encoding
  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;
  localparam logic [1:0] S_WAIT_I = 2'b01;
  localparam logic [1:0] S_WAIT_Q = 2'b10;

  // A pair word carries I in the upper half and Q in the lower half
  function automatic int unsigned pair_width(input int unsigned data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/gnrl_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output; output holds the
// last popped word while empty.
`timescale 1ns/1ps
module gnrl_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      level_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] head;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i & ~empty_o;
  // When full, a same-cycle pop frees the slot being written
  assign do_push = push_i & (~full_o | do_pop);

  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign rdata_o = empty_o ? last_q : head;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = head;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/gnrl_iq_deinterleaver.sv
// Re-pairs an interleaved I,Q word stream into parallel I/Q outputs through a pair FIFO,
// with sticky orphan/overflow flags and an accepted-pair counter.
`timescale 1ns/1ps
module gnrl_iq_deinterleaver
  import gnrl_iq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FIFO_AW    = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] dataI,
  output logic [DATA_WIDTH-1:0] dataQ,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  pair_cnt,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  orphan_err,
  output logic                  overflow_err,
  input  logic                  clr_err
);

  localparam int unsigned PAIR_W = pair_width(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] i_hold_q, i_hold_d;
  logic [CNT_WIDTH-1:0]  pair_cnt_q, pair_cnt_d;
  logic                  orphan_q, orphan_d;
  logic                  overflow_q, overflow_d;

  logic                  push_req, orphan_ev, overflow_ev;
  logic                  pop, push_ok;
  logic                  fifo_empty, fifo_full;
  logic [PAIR_W-1:0]     pair_wdata, pair_rdata;

  always_comb begin
    state_d   = state_q;
    i_hold_d  = i_hold_q;
    push_req  = 1'b0;
    orphan_ev = 1'b0;
    case (state_q)
      S_WAIT_I: begin
        if (in_valid) begin
          i_hold_d = datain;
          state_d  = S_WAIT_Q;
        end
      end
      S_WAIT_Q: begin
        // Q must follow I immediately; a gap breaks framing and the held I is discarded
        if (in_valid) push_req = 1'b1;
        else          orphan_ev = 1'b1;
        i_hold_d = '0;
        state_d  = S_WAIT_I;
      end
      default: begin
        i_hold_d = '0;
        state_d  = S_WAIT_I;
      end
    endcase
  end

  assign pair_wdata  = {i_hold_q, datain};
  assign pop         = out_ready & ~fifo_empty;
  assign push_ok     = push_req & (~fifo_full | pop);
  assign overflow_ev = push_req & fifo_full & ~pop;

  always_comb begin
    pair_cnt_d = pair_cnt_q + (push_ok ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
    // Set wins over a concurrent clear
    orphan_d   = (orphan_q & ~clr_err) | orphan_ev;
    overflow_d = (overflow_q & ~clr_err) | overflow_ev;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= S_WAIT_I;
      i_hold_q   <= '0;
      pair_cnt_q <= '0;
      orphan_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_hold_q   <= i_hold_d;
      pair_cnt_q <= pair_cnt_d;
      orphan_q   <= orphan_d;
      overflow_q <= overflow_d;
    end
  end

  gnrl_sync_fifo #(
    .WIDTH (PAIR_W),
    .AW    (FIFO_AW)
  ) u_pair_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET_n),
    .push_i  (push_ok),
    .wdata_i (pair_wdata),
    .pop_i   (pop),
    .rdata_o (pair_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign dataI        = pair_rdata[PAIR_W-1:DATA_WIDTH];
  assign dataQ        = pair_rdata[DATA_WIDTH-1:0];
  assign out_valid    = ~fifo_empty;
  assign pair_cnt     = pair_cnt_q;
  assign orphan_err   = orphan_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_gnrl_iq_deinterleaver.sv
// Directed self-checking bench for gnrl_iq_deinterleaver (DATA_WIDTH=32, FIFO_AW=3, CNT_WIDTH=16).
`timescale 1ns/1ps
module tb_gnrl_iq_deinterleaver;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic [31:0] datain;
  logic        in_valid;
  logic [31:0] dataI, dataQ;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pair_cnt;
  logic [3:0]  fifo_level;
  logic        orphan_err, overflow_err;
  logic        clr_err;

  int tests = 0;
  int fails = 0;

  gnrl_iq_deinterleaver #(
    .DATA_WIDTH (32),
    .FIFO_AW    (3),
    .CNT_WIDTH  (16)
  ) dut (
    .CLK          (CLK),
    .RESET_n      (RESET_n),
    .datain       (datain),
    .in_valid     (in_valid),
    .dataI        (dataI),
    .dataQ        (dataQ),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pair_cnt     (pair_cnt),
    .fifo_level   (fifo_level),
    .orphan_err   (orphan_err),
    .overflow_err (overflow_err),
    .clr_err      (clr_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    datain   = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    RESET_n   = 1'b0;
    datain    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dataI", dataI, 0);
    chk("rst_dataQ", dataQ, 0);
    chk("rst_pair_cnt", pair_cnt, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_orphan", orphan_err, 0);
    chk("rst_overflow", overflow_err, 0);
    RESET_n = 1'b1;

    // 1: single pair, one-cycle latency
    out_ready = 1'b1;
    send(32'h11);
    chk("t1_valid_after_I", out_valid, 0);
    send(32'h22);
    chk("t1_valid", out_valid, 1);
    chk("t1_dataI", dataI, 32'h11);
    chk("t1_dataQ", dataQ, 32'h22);
    chk("t1_cnt", pair_cnt, 1);
    chk("t1_level_1", fifo_level, 1);
    idle();
    chk("t1_valid_off", out_valid, 0);
    chk("t1_level_0", fifo_level, 0);
    chk("t1_hold_I", dataI, 32'h11);
    $display("[TB] t1 single pair done");

    // 2: pairs with idle gaps
    for (int k = 1; k <= 3; k++) begin
      send(32'h100 * k + 1);
      send(32'h100 * k + 2);
      chk("t2_valid", out_valid, 1);
      chk("t2_dataI", dataI, 32'h100 * k + 1);
      chk("t2_dataQ", dataQ, 32'h100 * k + 2);
      idle();
      if (k != 2) idle();
      chk("t2_empty", out_valid, 0);
      $display("[TB] t2 pair %0d done", k);
    end
    chk("t2_cnt", pair_cnt, 4);
    chk("t2_orphan", orphan_err, 0);
    chk("t2_overflow", overflow_err, 0);

    // 3: orphan I
    send(32'hA1);
    idle();
    chk("t3_orphan", orphan_err, 1);
    chk("t3_no_out", out_valid, 0);
    send(32'hB1);
    send(32'hB2);
    chk("t3_valid", out_valid, 1);
    chk("t3_dataI", dataI, 32'hB1);
    chk("t3_dataQ", dataQ, 32'hB2);
    idle();
    chk("t3_empty", out_valid, 0);
    chk("t3_cnt", pair_cnt, 5);
    clr_err = 1'b1;
    idle();
    clr_err = 1'b0;
    chk("t3_orphan_clr", orphan_err, 0);
    $display("[TB] t3 orphan done");

    // 4: overflow with 9 pairs into depth 8
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      send(32'h1000 + k);
      send(32'h2000 + k);
    end
    chk("t4_level8", fifo_level, 8);
    chk("t4_no_ovf_yet", overflow_err, 0);
    chk("t4_head_I", dataI, 32'h1001);
    send(32'h1009);
    send(32'h2009);
    chk("t4_level_cap", fifo_level, 8);
    chk("t4_overflow", overflow_err, 1);
    chk("t4_cnt", pair_cnt, 13);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("t4_drain_I", dataI, 32'h1000 + k);
      chk("t4_drain_Q", dataQ, 32'h2000 + k);
      idle();
    end
    chk("t4_drained", out_valid, 0);
    chk("t4_level0", fifo_level, 0);
    $display("[TB] t4 overflow done");

    // 5: full FIFO, Q coincides with pop
    clr_err = 1'b1;
    idle();
    clr_err = 1'b0;
    chk("t5_ovf_clr", overflow_err, 0);
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      send(32'h3000 + k);
      send(32'h4000 + k);
    end
    chk("t5_full", fifo_level, 8);
    send(32'h3009);
    out_ready = 1'b1;
    send(32'h4009);
    chk("t5_level", fifo_level, 8);
    chk("t5_no_ovf", overflow_err, 0);
    chk("t5_cnt", pair_cnt, 22);
    for (int k = 2; k <= 9; k++) begin
      chk("t5_drain_I", dataI, 32'h3000 + k);
      chk("t5_drain_Q", dataQ, 32'h4000 + k);
      idle();
    end
    chk("t5_level0", fifo_level, 0);
    $display("[TB] t5 push+pop at full done");

    // 6: reset between I and Q with 3 pairs buffered
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      send(32'h5000 + k);
      send(32'h6000 + k);
    end
    chk("t6_level3", fifo_level, 3);
    chk("t6_cnt", pair_cnt, 25);
    send(32'h7001);
    #2;
    RESET_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_cnt", pair_cnt, 0);
    chk("t6_rst_dataI", dataI, 0);
    chk("t6_rst_dataQ", dataQ, 0);
    tick();
    RESET_n = 1'b1;
    idle();
    chk("t6_no_pulse", out_valid, 0);
    out_ready = 1'b1;
    send(32'h8001);
    chk("t6_first_is_I", out_valid, 0);
    send(32'h8002);
    chk("t6_dataI", dataI, 32'h8001);
    chk("t6_dataQ", dataQ, 32'h8002);
    chk("t6_cnt1", pair_cnt, 1);
    chk("t6_no_orphan", orphan_err, 0);
    idle();
    send(32'h9001);
    clr_err = 1'b1;
    idle();
    chk("t6_set_wins", orphan_err, 1);
    idle();
    clr_err = 1'b0;
    chk("t6_clr", orphan_err, 0);
    chk("t6_ovf", overflow_err, 0);
    $display("[TB] t6 mid-op reset done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
